// File: rtl/calc_pkg.sv
// Shared definitions for the calculator load sequencer: the phase
// encoding shown on the board LEDs and the default operand width.
package calc_pkg;

    // Default operand/result width: IEEE half precision.
    localparam int CALC_WORD = 16;

    // Sequencer phases; the numeric values drive the phase LEDs directly.
    typedef enum logic [1:0] {
        ENTER_A  = 2'd0,
        ENTER_B  = 2'd1,
        WAIT_SUM = 2'd2,
        SHOW     = 2'd3
    } calc_phase_t;

endpackage

// File: rtl/pb_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability debouncer and
// rising-edge detector. Emits a registered one-cycle press pulse per
// accepted press; releases produce nothing.
module pb_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic pb_i,
    output logic press_o
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Count consecutive cycles the synchronized level disagrees with the
    // accepted level; any agreement (i.e. a bounce back) restarts the count.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        press_d = level_d & ~level_q;
    end

    // Synchronizer, debounce state and press pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= pb_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/calc_load_sequencer.sv
// Calculator operand load sequencer: loads operand A then B from the
// keypad entry on debounced "enter" presses, waits for the external adder
// to settle, samples its sum for display, and handles "clear" from any phase.
module calc_load_sequencer
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int ADD_LATENCY     = 2,
    parameter int WORD            = CALC_WORD
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enter_pb,
    input  logic            clear_pb,
    input  logic [WORD-1:0] entry,
    input  logic [WORD-1:0] sum,
    output logic [WORD-1:0] op_a,
    output logic [WORD-1:0] op_b,
    output logic [WORD-1:0] result,
    output logic            result_valid,
    output logic            entry_clr,
    output logic [1:0]      phase
);

    // Latency counter is 4 bits: ADD_LATENCY is limited to 1..15.
    localparam logic [3:0] LAT_LAST = 4'(ADD_LATENCY - 1);

    logic enter_press, clear_press;

    calc_phase_t     state_q, state_d;
    logic [WORD-1:0] op_a_q, op_a_d;
    logic [WORD-1:0] op_b_q, op_b_d;
    logic [WORD-1:0] res_q, res_d;
    logic            vld_q, vld_d;
    logic            clr_q, clr_d;
    logic [3:0]      lat_q, lat_d;

    pb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_db (
        .clk     (clk),
        .reset   (reset),
        .pb_i    (enter_pb),
        .press_o (enter_press)
    );

    pb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
        .clk     (clk),
        .reset   (reset),
        .pb_i    (clear_pb),
        .press_o (clear_press)
    );

    // Next-state logic; clear takes priority over enter in every phase,
    // and enter presses arriving during WAIT_SUM are simply ignored.
    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        res_d   = res_q;
        vld_d   = vld_q;
        clr_d   = 1'b0;
        lat_d   = lat_q;
        if (clear_press) begin
            op_a_d  = '0;
            op_b_d  = '0;
            res_d   = '0;
            vld_d   = 1'b0;
            clr_d   = 1'b1;
            state_d = ENTER_A;
        end else begin
            case (state_q)
                ENTER_A: begin
                    if (enter_press) begin
                        op_a_d  = entry;
                        clr_d   = 1'b1;
                        vld_d   = 1'b0;
                        state_d = ENTER_B;
                    end
                end
                ENTER_B: begin
                    if (enter_press) begin
                        op_b_d  = entry;
                        clr_d   = 1'b1;
                        lat_d   = '0;
                        state_d = WAIT_SUM;
                    end
                end
                WAIT_SUM: begin
                    if (lat_q == LAT_LAST) begin
                        res_d   = sum;
                        vld_d   = 1'b1;
                        state_d = SHOW;
                    end else begin
                        lat_d = lat_q + 4'd1;
                    end
                end
                SHOW: begin
                    // Operands and result stay on display until A is re-entered.
                    if (enter_press) begin
                        state_d = ENTER_A;
                    end
                end
                default: state_d = ENTER_A;
            endcase
        end
    end

    // State, operand, result and strobe registers; reset aborts any phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ENTER_A;
            op_a_q  <= '0;
            op_b_q  <= '0;
            res_q   <= '0;
            vld_q   <= 1'b0;
            clr_q   <= 1'b0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            res_q   <= res_d;
            vld_q   <= vld_d;
            clr_q   <= clr_d;
            lat_q   <= lat_d;
        end
    end

    assign op_a         = op_a_q;
    assign op_b         = op_b_q;
    assign result       = res_q;
    assign result_valid = vld_q;
    assign entry_clr    = clr_q;
    assign phase        = state_q;

endmodule

// File: tb/tb_calc_load_sequencer.sv
// Bench for calc_load_sequencer: directed scenarios with literal
// expectations followed by randomized button traffic, all checked each
// cycle against a behavioural model of the button/phase rules.
module tb_calc_load_sequencer;

    localparam int DB = 4;
    localparam int AL = 2;
    localparam int W  = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         enter_pb = 1'b0;
    logic         clear_pb = 1'b0;
    logic [W-1:0] entry = '0;
    logic [W-1:0] sum;
    logic [W-1:0] op_a, op_b, result;
    logic         result_valid, entry_clr;
    logic [1:0]   phase;

    int n_checks = 0;
    int n_fails  = 0;
    int clr_cnt  = 0;
    bit chk_en   = 1'b0;

    calc_load_sequencer #(
        .DEBOUNCE_CYCLES(DB),
        .ADD_LATENCY    (AL),
        .WORD           (W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enter_pb     (enter_pb),
        .clear_pb     (clear_pb),
        .entry        (entry),
        .sum          (sum),
        .op_a         (op_a),
        .op_b         (op_b),
        .result       (result),
        .result_valid (result_valid),
        .entry_clr    (entry_clr),
        .phase        (phase)
    );

    always #10 clk = ~clk;

    // ---------------- half-precision adder model (external adder) ----------
    function automatic real pow2(input int k);
        real r = 1.0;
        if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
        else        for (int i = 0; i < -k; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real hp_to_real(input logic [15:0] h);
        int  e = int'(h[14:10]);
        real r;
        if (e == 0) r = (real'(h[9:0]) / 1024.0) * pow2(-14);
        else        r = (1.0 + real'(h[9:0]) / 1024.0) * pow2(e - 15);
        if (e == 31) r = 65536.0;
        return h[15] ? -r : r;
    endfunction

    function automatic logic [15:0] real_to_hp(input real r);
        logic s = (r < 0.0);
        real  a = s ? -r : r;
        int   e = 15;
        int   bits;
        if (a == 0.0) return 16'h0000;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0 && e > 1) begin a = a * 2.0; e--; end
        if (a < 1.0) bits = $rtoi(a * 1024.0 + 0.5);
        else         bits = e * 1024 + $rtoi((a - 1.0) * 1024.0 + 0.5);
        if (bits >= 31 * 1024) bits = 31 * 1024;
        return {s, 15'(bits)};
    endfunction

    function automatic logic [15:0] hp_add(input logic [15:0] a, input logic [15:0] b);
        return real_to_hp(hp_to_real(a) + hp_to_real(b));
    endfunction

    always_comb sum = hp_add(op_a, op_b);

    // ---------------- behavioural model ------------------------------------
    // Buttons: raw level reaches the debouncer two edges later; the accepted
    // level flips once the last DB synchronized samples all disagree with it.
    bit          m_s1e, m_s2e, m_s1c, m_s2c, m_debE, m_debC, m_pe, m_pc;
    bit          he[DB];
    bit          hc[DB];
    int          m_phase, m_wait;
    logic [15:0] m_a, m_b, m_res;
    bit          m_vld, m_clr;

    always @(posedge clk) begin
        bit pe, pc, s2e, s2c, nde, ndc, alle, allc;
        pe = m_pe;
        pc = m_pc;
        if (reset) begin
            m_s1e = 0; m_s2e = 0; m_s1c = 0; m_s2c = 0;
            m_debE = 0; m_debC = 0; m_pe = 0; m_pc = 0;
            for (int i = 0; i < DB; i++) begin he[i] = 0; hc[i] = 0; end
            m_phase = 0; m_wait = 0;
            m_a = '0; m_b = '0; m_res = '0; m_vld = 0; m_clr = 0;
        end else begin
            s2e = m_s2e; s2c = m_s2c;
            m_s2e = m_s1e; m_s1e = enter_pb;
            m_s2c = m_s1c; m_s1c = clear_pb;
            for (int i = DB - 1; i > 0; i--) begin he[i] = he[i-1]; hc[i] = hc[i-1]; end
            he[0] = s2e; hc[0] = s2c;
            alle = 1; allc = 1;
            for (int i = 0; i < DB; i++) begin
                if (he[i] == m_debE) alle = 0;
                if (hc[i] == m_debC) allc = 0;
            end
            nde = alle ? ~m_debE : m_debE;
            ndc = allc ? ~m_debC : m_debC;
            m_pe = nde & ~m_debE; m_debE = nde;
            m_pc = ndc & ~m_debC; m_debC = ndc;

            m_clr = 0;
            if (pc) begin
                m_a = '0; m_b = '0; m_res = '0; m_vld = 0; m_clr = 1; m_phase = 0;
            end else begin
                case (m_phase)
                    0: if (pe) begin m_a = entry; m_clr = 1; m_vld = 0; m_phase = 1; end
                    1: if (pe) begin m_b = entry; m_clr = 1; m_wait = 0; m_phase = 2; end
                    2: begin
                        m_wait++;
                        if (m_wait == AL) begin m_res = hp_add(m_a, m_b); m_vld = 1; m_phase = 3; end
                    end
                    default: if (pe) m_phase = 0;
                endcase
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            n_checks++;
            if (phase !== 2'(m_phase) || op_a !== m_a || op_b !== m_b || result !== m_res ||
                result_valid !== m_vld || entry_clr !== m_clr) begin
                n_fails++;
                $display("FAIL model_cmp t=%0t got phase=%0d a=%h b=%h res=%h vld=%b clr=%b exp phase=%0d a=%h b=%h res=%h vld=%b clr=%b",
                         $time, phase, op_a, op_b, result, result_valid, entry_clr,
                         m_phase, m_a, m_b, m_res, m_vld, m_clr);
            end
        end
        if (entry_clr === 1'b1) clr_cnt++;
    end

    // ---------------- helpers ----------------------------------------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input bit e, input bit c, input int hold, input int gap);
        enter_pb = e; clear_pb = c;
        cyc(hold);
        enter_pb = 0; clear_pb = 0;
        cyc(gap);
    endtask

    int base;
    bit seen;

    initial begin
        cyc(3);
        chk_en = 1;
        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_op_a", 32'(op_a), 32'h0);
        chk("rst_valid", 32'(result_valid), 32'd0);
        chk("rst_clr", 32'(entry_clr), 32'd0);
        reset = 0;
        cyc(2);

        // 1.0 + 2.0 = 3.0 with two entry clears
        base = clr_cnt;
        entry = 16'h3C00; press(1, 0, 8, 10);
        entry = 16'h4000; press(1, 0, 8, 10);
        chk("add_op_a", 32'(op_a), 32'h3C00);
        chk("add_op_b", 32'(op_b), 32'h4000);
        chk("add_result", 32'(result), 32'h4200);
        chk("add_valid", 32'(result_valid), 32'd1);
        chk("add_phase", 32'(phase), 32'd3);
        chk("add_clr_pulses", 32'(clr_cnt - base), 32'd2);

        // SHOW -> ENTER_A keeps the result until A is re-entered
        press(1, 0, 8, 10);
        chk("show_phase", 32'(phase), 32'd0);
        chk("show_result", 32'(result), 32'h4200);
        chk("show_valid", 32'(result_valid), 32'd1);
        entry = 16'h3800; press(1, 0, 8, 10);
        chk("reA_phase", 32'(phase), 32'd1);
        chk("reA_valid", 32'(result_valid), 32'd0);
        chk("reA_op_a", 32'(op_a), 32'h3800);

        // Reset while waiting for the sum
        entry = 16'h4400;
        enter_pb = 1;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (phase == 2'd2) seen = 1;
        end
        chk("wait_reached", 32'(seen), 32'd1);
        enter_pb = 0; reset = 1;
        @(negedge clk);
        reset = 0;
        chk("rst_wait_phase", 32'(phase), 32'd0);
        chk("rst_wait_valid", 32'(result_valid), 32'd0);
        chk("rst_wait_result", 32'(result), 32'h0);
        base = clr_cnt;
        cyc(10);
        chk("rst_wait_noclr", 32'(clr_cnt - base), 32'd0);

        // Simultaneous enter + clear in ENTER_B: clear wins
        entry = 16'h4000; press(1, 0, 8, 10);
        base = clr_cnt;
        press(1, 1, 8, 10);
        chk("both_phase", 32'(phase), 32'd0);
        chk("both_op_a", 32'(op_a), 32'h0);
        chk("both_op_b", 32'(op_b), 32'h0);
        chk("both_result", 32'(result), 32'h0);
        chk("both_clr", 32'(clr_cnt - base), 32'd1);

        // Bouncing press counts once
        base = clr_cnt;
        enter_pb = 1; cyc(1); enter_pb = 0; cyc(1);
        enter_pb = 1; cyc(1); enter_pb = 0; cyc(1);
        press(1, 0, 10, 10);
        chk("bounce_phase", 32'(phase), 32'd1);
        chk("bounce_clr", 32'(clr_cnt - base), 32'd1);

        // Too-short press is ignored
        base = clr_cnt;
        press(1, 0, 3, 10);
        chk("short_phase", 32'(phase), 32'd1);
        chk("short_clr", 32'(clr_cnt - base), 32'd0);

        // Randomized button traffic checked by the model
        for (int it = 0; it < 150; it++) begin
            int act = int'($urandom_range(0, 9));
            entry = {1'($urandom), 5'($urandom_range(5, 25)), 10'($urandom)};
            if (act == 0) begin
                reset = 1; cyc(int'($urandom_range(1, 3))); reset = 0;
            end else if (act == 1) begin
                press(0, 1, int'($urandom_range(1, 9)), int'($urandom_range(1, 9)));
            end else if (act == 2) begin
                press(1, 1, int'($urandom_range(3, 9)), int'($urandom_range(1, 9)));
            end else begin
                press(1, 0, int'($urandom_range(1, 9)), int'($urandom_range(1, 9)));
            end
        end
        cyc(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
